// File: rtl/ram_access_scheduler.sv
// Round-robin scheduler sharing one single-port RAM between a write port (0) and two
// read ports (1, 2). One transaction in flight at a time; one-cycle ack per completion.
module ram_access_scheduler #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 28,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] wrAddr0,
    input  logic [DATA_W-1:0] wrData0,
    input  logic [ADDR_W-1:0] rdAddr1,
    input  logic [ADDR_W-1:0] rdAddr2,
    input  logic [DATA_W-1:0] ramQ,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramData,
    output logic              ramWren,
    output logic [2:0]        ack,
    output logic [DATA_W-1:0] rdData,
    output logic [1:0]        grantId,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StGrant, StWait, StResp} stateT;

    stateT             stateQ, stateD;
    logic [1:0]        grantQ, grantD;
    logic [1:0]        lastQ, lastD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [DATA_W-1:0] dataQ, dataD;
    logic [DATA_W-1:0] rdDataQ, rdDataD;
    logic [2:0]        cntQ, cntD;
    logic [1:0]        first, second, third, pick;

    // Search order starts one past the last served port.
    always_comb begin
        case (lastQ)
            2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
            2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
            default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
        endcase
        if (req[first]) begin
            pick = first;
        end else if (req[second]) begin
            pick = second;
        end else begin
            pick = third;
        end
    end

    always_comb begin
        stateD  = stateQ;
        grantD  = grantQ;
        lastD   = lastQ;
        addrD   = addrQ;
        dataD   = dataQ;
        rdDataD = rdDataQ;
        cntD    = cntQ;
        case (stateQ)
            StIdle: begin
                if (req != 3'b000) begin
                    grantD = pick;
                    stateD = StGrant;
                    case (pick)
                        2'd0: begin
                            addrD = wrAddr0;
                            dataD = wrData0;
                        end
                        2'd1:    addrD = rdAddr1;
                        default: addrD = rdAddr2;
                    endcase
                end
            end
            StGrant: begin
                if (grantQ == 2'd0) begin
                    stateD = StResp;
                end else begin
                    cntD   = 3'(READ_LATENCY);
                    stateD = StWait;
                end
            end
            StWait: begin
                if (cntQ == 3'd1) begin
                    rdDataD = ramQ;
                    stateD  = StResp;
                end else begin
                    cntD = cntQ - 3'd1;
                end
            end
            StResp: begin
                lastD  = grantQ;
                grantD = 2'd3;
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateQ  <= StIdle;
            grantQ  <= 2'd3;
            lastQ   <= 2'd2;
            addrQ   <= '0;
            dataQ   <= '0;
            rdDataQ <= '0;
            cntQ    <= 3'd0;
        end else begin
            stateQ  <= stateD;
            grantQ  <= grantD;
            lastQ   <= lastD;
            addrQ   <= addrD;
            dataQ   <= dataD;
            rdDataQ <= rdDataD;
            cntQ    <= cntD;
        end
    end

    // Decoded from registered state so an async reset drops them immediately.
    always_comb begin
        ack = 3'b000;
        if (stateQ == StResp) begin
            case (grantQ)
                2'd0:    ack = 3'b001;
                2'd1:    ack = 3'b010;
                2'd2:    ack = 3'b100;
                default: ack = 3'b000;
            endcase
        end
    end

    assign ramWren = (stateQ == StGrant) && (grantQ == 2'd0);
    assign ramAddr = addrQ;
    assign ramData = dataQ;
    assign rdData  = rdDataQ;
    assign grantId = grantQ;
    assign busy    = (stateQ != StIdle);

endmodule

// File: tb/tb_ram_access_scheduler.sv
// Scoreboard bench for ram_access_scheduler with a two-stage registered RAM model.
module tb_ram_access_scheduler;

    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned DATA_W       = 28;
    localparam int unsigned READ_LATENCY = 2;

    logic              clk = 1'b0;
    logic              resetN;
    logic [2:0]        req;
    logic [ADDR_W-1:0] wrAddr0, rdAddr1, rdAddr2;
    logic [DATA_W-1:0] wrData0;
    logic [DATA_W-1:0] ramQ;
    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] ramData;
    logic              ramWren;
    logic [2:0]        ack;
    logic [DATA_W-1:0] rdData;
    logic [1:0]        grantId;
    logic              busy;

    always #5 clk = ~clk;

    ram_access_scheduler #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .READ_LATENCY(READ_LATENCY)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .req    (req),
        .wrAddr0(wrAddr0),
        .wrData0(wrData0),
        .rdAddr1(rdAddr1),
        .rdAddr2(rdAddr2),
        .ramQ   (ramQ),
        .ramAddr(ramAddr),
        .ramData(ramData),
        .ramWren(ramWren),
        .ack    (ack),
        .rdData (rdData),
        .grantId(grantId),
        .busy   (busy)
    );

    // RAM model: address register then output register (two edges to valid q).
    logic [DATA_W-1:0] mem [0:255];
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] qReg;
    logic              preWe;
    logic [ADDR_W-1:0] preAddr;
    logic [DATA_W-1:0] preData;

    always @(posedge clk) begin
        if (preWe) mem[preAddr] <= preData;
        else if (ramWren) mem[ramAddr] <= ramData;
        addrReg <= ramAddr;
        qReg    <= mem[addrReg];
    end
    assign ramQ = qReg;

    typedef struct packed {
        logic [1:0]        port;
        logic [DATA_W-1:0] data;
    } expT;

    expT expQ[$];
    int  checks     = 0;
    int  failures   = 0;
    int  ackCount   = 0;
    int  wrenCount  = 0;
    int  grant2Count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitAcks(input int target, input int bound);
        int cycles;
        cycles = 0;
        while (ackCount < target && cycles < bound) begin
            tick();
            cycles++;
        end
        check("ack timeout", 32'(ackCount >= target), 32'd1);
    endtask

    // Monitor: pops the scoreboard whenever an ack is presented.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (resetN) begin
                if (ramWren) wrenCount++;
                if (grantId == 2'd2) grant2Count++;
                if (ack != 3'b000) begin
                    check("ack onehot", 32'($countones(ack)), 32'd1);
                    if (expQ.size() == 0) begin
                        check("unexpected ack", 32'(ack), 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        check("ack port", 32'(ack), 32'(3'b001 << e.port));
                        if (e.port != 2'd0) check("rdData", 32'(rdData), 32'(e.data));
                    end
                    ackCount++;
                end
            end
        end
    end

    initial begin
        int n0, wc, g2, lat;
        resetN = 1'b0; req = 3'b000; wrAddr0 = '0; wrData0 = '0; rdAddr1 = '0; rdAddr2 = '0;
        preWe = 1'b0; preAddr = '0; preData = '0;
        tick();
        preWe = 1'b1; preAddr = 8'h07; preData = 28'h1234567;
        tick();
        preWe = 1'b0;

        check("reset busy", 32'(busy), 32'd0);
        check("reset grantId", 32'(grantId), 32'd3);
        check("reset ack", 32'(ack), 32'd0);
        check("reset ramWren", 32'(ramWren), 32'd0);
        check("reset ramAddr", 32'(ramAddr), 32'd0);
        check("reset ramData", 32'(ramData), 32'd0);
        check("reset rdData", 32'(rdData), 32'd0);
        resetN = 1'b1;
        tick();

        // Single write
        expQ.push_back({2'd0, 28'd0});
        req = 3'b001; wrAddr0 = 8'h05; wrData0 = 28'd4567;
        tick();
        check("wr grant ramWren", 32'(ramWren), 32'd1);
        check("wr grant ramAddr", 32'(ramAddr), 32'h05);
        check("wr grant ramData", 32'(ramData), 32'd4567);
        check("wr grant grantId", 32'(grantId), 32'd0);
        check("wr grant busy", 32'(busy), 32'd1);
        tick();
        check("wr resp ramWren", 32'(ramWren), 32'd0);
        check("wr resp ack", 32'(ack), 32'b001);
        req = 3'b000;
        tick();
        check("wr idle grantId", 32'(grantId), 32'd3);
        check("wr idle busy", 32'(busy), 32'd0);
        check("wr ram contents", 32'(mem[5]), 32'd4567);

        // Read-after-write
        wc = wrenCount;
        expQ.push_back({2'd1, 28'd4567});
        req = 3'b010; rdAddr1 = 8'h05;
        lat = 0;
        while (ack[1] !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        check("rd latency", 32'(lat), 32'd4);
        req = 3'b000;
        tick();
        tick();
        check("rd no wren", 32'(wrenCount), 32'(wc));

        // Contention from reset: expect 0,1,2,0,1,2
        resetN = 1'b0;
        req = 3'b111; wrAddr0 = 8'h09; wrData0 = 28'd111; rdAddr1 = 8'h05; rdAddr2 = 8'h07;
        for (int i = 0; i < 2; i++) begin
            expQ.push_back({2'd0, 28'd0});
            expQ.push_back({2'd1, 28'd4567});
            expQ.push_back({2'd2, 28'h1234567});
        end
        tick();
        resetN = 1'b1;
        n0 = ackCount;
        waitAcks(n0 + 6, 100);
        req = 3'b000;
        repeat (3) tick();
        check("contention idle", 32'(busy), 32'd0);

        // Withdrawal: req[2] pulsed during a write GRANT
        g2 = grant2Count;
        n0 = ackCount;
        expQ.push_back({2'd0, 28'd0});
        req = 3'b001; wrAddr0 = 8'h0A; wrData0 = 28'd222;
        tick();
        check("wd grantId", 32'(grantId), 32'd0);
        req = 3'b101;
        tick();
        req = 3'b000;
        repeat (6) tick();
        check("wd ack count", 32'(ackCount), 32'(n0 + 1));
        check("wd no grant2", 32'(grant2Count), 32'(g2));
        check("wd idle", 32'(busy), 32'd0);

        // Late drop and address change
        n0 = ackCount;
        expQ.push_back({2'd1, 28'd4567});
        req = 3'b010; rdAddr1 = 8'h05;
        tick();
        req = 3'b000; rdAddr1 = 8'h07;
        tick();
        check("late ramAddr", 32'(ramAddr), 32'h05);
        waitAcks(n0 + 1, 10);
        repeat (2) tick();

        // Async reset during WAIT
        req = 3'b010; rdAddr1 = 8'h07;
        tick();
        req = 3'b000;
        tick();
        #2;
        resetN = 1'b0;
        #1;
        check("arst busy", 32'(busy), 32'd0);
        check("arst grantId", 32'(grantId), 32'd3);
        check("arst ack", 32'(ack), 32'd0);
        check("arst ramWren", 32'(ramWren), 32'd0);
        req = 3'b111; wrAddr0 = 8'h0B; wrData0 = 28'd333;
        expQ.push_back({2'd0, 28'd0});
        #3;
        resetN = 1'b1;
        n0 = ackCount;
        waitAcks(n0 + 1, 20);
        req = 3'b000;
        repeat (4) tick();
        check("final idle", 32'(busy), 32'd0);
        check("scoreboard empty", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
